// File: rtl/wfifo_pkg.sv
// rtl/wfifo_pkg.sv - shared pointer types and Gray/binary helpers for the dual-clock FIFO
package wfifo_pkg;

    localparam int MAX_ADDRSIZE = 12;

    // Wide container; callers size-cast results back to their ADDRSIZE+1 pointer width.
    typedef logic [MAX_ADDRSIZE:0] ptr_t;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic ptr_t width_mask(input int width);
        return (ptr_t'(1) << width) - ptr_t'(1);
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b, input int width);
        ptr_t g;
        g = (b >> 1) ^ b;
        return g & width_mask(width);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g, input int width);
        ptr_t b;
        b = g & width_mask(width);
        for (int s = 1; s <= MAX_ADDRSIZE; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - multi-flop synchroniser for a Gray pointer crossing into the local clock domain
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] async_ptr_i,
    output logic [WIDTH-1:0] sync_ptr_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_ptr_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_ptr_o = stage_q[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-side pointer, full/almost-full/overflow flags of the dual-clock FIFO
// Define WPTR_LEVEL_EN to add the registered wlevel occupancy output.
module wptr_full_ctrl
    import wfifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                woverflow_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic                woverflow
`ifdef WPTR_LEVEL_EN
    ,
    output logic [ADDRSIZE:0]   wlevel
`endif
);

    localparam int A  = ADDRSIZE;
    localparam int PW = ADDRSIZE + 1;
    localparam logic [A:0] AFULL_TH = PW'(fifo_depth(ADDRSIZE) - AFULL_MARGIN);

    logic [A:0] wbin_q, wbin_d;
    logic [A:0] wgray_q, wgray_d;
    logic [A:0] wq_rptr, rbin_s, lvl_next;
    logic       wpush;
    logic       wfull_q, wfull_d;
    logic       wafull_q, wafull_d;
    logic       wovf_q, wovf_d;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .async_ptr_i (rptr),
        .sync_ptr_o  (wq_rptr)
    );

    // wfull is the registered flag, so a slot freed this cycle is not usable until the next one.
    always_comb begin
        wpush    = winc & ~wfull_q;
        wbin_d   = wbin_q + {{A{1'b0}}, wpush};
        wgray_d  = PW'(bin2gray(ptr_t'(wbin_d), PW));
        rbin_s   = PW'(gray2bin(ptr_t'(wq_rptr), PW));
        lvl_next = wbin_d - rbin_s;
        wfull_d  = (wgray_d == {~wq_rptr[A:A-1], wq_rptr[A-2:0]});
        wafull_d = (lvl_next >= AFULL_TH);
        wovf_d   = (winc & wfull_q) | (wovf_q & ~woverflow_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

`ifdef WPTR_LEVEL_EN
    logic [A:0] wlevel_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel_q <= '0;
        end else begin
            wlevel_q <= lvl_next;
        end
    end

    assign wlevel = wlevel_q;
`endif

    assign waddr        = wbin_q[A-1:0];
    assign wptr         = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - randomized self-checking bench for wptr_full_ctrl against an occupancy-count model
module tb_wptr_full_ctrl;

    localparam int A     = 4;
    localparam int DEPTH = 16;

    logic         wclk          = 1'b0;
    logic         wrst_n        = 1'b0;
    logic         winc          = 1'b0;
    logic         woverflow_clr = 1'b0;
    logic [A:0]   rptr          = '0;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         wfull, walmost_full, woverflow;
`ifdef WPTR_LEVEL_EN
    logic [A:0]   wlevel;
`endif

    int errors = 0;
    int checks = 0;

    // Model works in unbounded write/read counts rather than wrapped pointers.
    int m_wcnt, m_rcnt, m_lvl;
    int m_hist[2];
    bit m_full, m_afull, m_ovf;

    always #5 wclk = ~wclk;

    wptr_full_ctrl #(
        .ADDRSIZE     (A),
        .SYNC_STAGES  (2),
        .AFULL_MARGIN (2)
    ) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .winc          (winc),
        .rptr          (rptr),
        .woverflow_clr (woverflow_clr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .woverflow     (woverflow)
`ifdef WPTR_LEVEL_EN
        ,
        .wlevel        (wlevel)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [A:0] gray(input int n);
        logic [A:0] b;
        b = (A+1)'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wcnt    = 0;
        m_rcnt    = 0;
        m_lvl     = 0;
        m_hist[0] = 0;
        m_hist[1] = 0;
        m_full    = 1'b0;
        m_afull   = 1'b0;
        m_ovf     = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".waddr"}, 32'(waddr), 32'(m_wcnt % DEPTH));
        check({tag, ".wptr"}, 32'(wptr), 32'(gray(m_wcnt)));
        check({tag, ".wfull"}, 32'(wfull), 32'(m_full));
        check({tag, ".walmost_full"}, 32'(walmost_full), 32'(m_afull));
        check({tag, ".woverflow"}, 32'(woverflow), 32'(m_ovf));
`ifdef WPTR_LEVEL_EN
        check({tag, ".wlevel"}, 32'(wlevel), 32'(m_lvl));
`endif
    endtask

    // One wclk edge: drive inputs, advance model, sample outputs 1 time unit after the edge.
    task automatic step(input string tag, input bit w, input bit clr);
        int  rs;
        bit  accept;
        winc          = w;
        woverflow_clr = clr;
        rptr          = gray(m_rcnt);
        @(posedge wclk);
        rs        = m_hist[0];
        accept    = w && !m_full;
        m_ovf     = (w && m_full) || (m_ovf && !clr);
        m_wcnt    = m_wcnt + int'(accept);
        m_lvl     = m_wcnt - rs;
        m_full    = (m_lvl == DEPTH);
        m_afull   = (m_lvl >= DEPTH - 2);
        m_hist[0] = m_hist[1];
        m_hist[1] = m_rcnt;
        #1;
        check_outputs(tag);
        winc          = 1'b0;
        woverflow_clr = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2;
        wrst_n        = 1'b0;
        winc          = 1'b0;
        woverflow_clr = 1'b0;
        rptr          = '0;
        model_reset();
        #1;
        check_outputs(tag);
        check({tag, ".wptr0"}, 32'(wptr), 32'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("por");
        repeat (2) @(posedge wclk);
        #1;
        check_outputs("por_hold");
        wrst_n = 1'b1;

        // Reset mid-burst, then first write after release
        for (int i = 0; i < 5; i++) step("burst", 1'b1, 1'b0);
        do_reset("mid_rst");
        check("first_waddr", 32'(waddr), 32'd0);
        step("first_wr", 1'b1, 1'b0);
        check("first_wptr", 32'(wptr), 32'b00001);

        // Fill
        do_reset("pre_fill");
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1'b1, 1'b0);
            if (i == 13) check("afull_before_14", 32'(walmost_full), 32'd0);
            if (i == 14) check("afull_at_14", 32'(walmost_full), 32'd1);
            if (i == 15) check("full_before_16", 32'(wfull), 32'd0);
        end
        check("full_at_16", 32'(wfull), 32'd1);
        check("fill_waddr_wrap", 32'(waddr), 32'd0);
        check("fill_wptr", 32'(wptr), 32'b11000);

        // Overflow and its clear priority
        for (int i = 0; i < 3; i++) begin
            step("ovf", 1'b1, 1'b0);
            check("ovf_wptr_hold", 32'(wptr), 32'b11000);
            check("ovf_set", 32'(woverflow), 32'd1);
        end
        step("ovf_sticky", 1'b0, 1'b0);
        check("ovf_sticky", 32'(woverflow), 32'd1);
        step("ovf_clr", 1'b0, 1'b1);
        check("ovf_clr", 32'(woverflow), 32'd0);
        step("ovf_set_wins", 1'b1, 1'b1);
        check("ovf_set_wins", 32'(woverflow), 32'd1);
        step("ovf_clr2", 1'b0, 1'b1);

        // Release from full after the read pointer advances
        m_rcnt = 1;
        step("rel1", 1'b0, 1'b0);
        check("rel_edge1", 32'(wfull), 32'd1);
        step("rel2", 1'b0, 1'b0);
        check("rel_edge2", 32'(wfull), 32'd1);
        step("rel3", 1'b0, 1'b0);
        check("rel_edge3", 32'(wfull), 32'd0);
        step("refill", 1'b1, 1'b0);
        check("refill_full", 32'(wfull), 32'd1);
        check("refill_wptr", 32'(wptr), 32'b11001);

        // Wrap with reader trailing three behind
        do_reset("pre_wrap");
        for (int i = 0; i < 40; i++) begin
            m_rcnt = (m_wcnt > 3) ? m_wcnt - 3 : 0;
            step("wrap", 1'b1, 1'b0);
            check("wrap_nofull", 32'(wfull), 32'd0);
            if (m_wcnt == 32) check("wrap_to_zero", 32'(wptr), 32'd0);
        end

        // Randomized traffic with a reset in the middle
        do_reset("pre_rand");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("rand_rst");
            if (m_rcnt < m_wcnt && $urandom_range(0, 2) == 0) m_rcnt++;
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
